// File: rtl/dmem_mmio_bridge_pkg.sv
// Shared MMIO address map for the data-memory bridge, the assembler test programs and the synth.
// The processor reaches this window with negative immediates, e.g. sw to -1(r0).
package mmio_defs;

    localparam logic [23:0] MMIO_PREFIX   = 24'hFFFFFF;
    localparam logic [7:0]  OFF_RX_DATA   = 8'hFF;
    localparam logic [7:0]  OFF_RX_STATUS = 8'hFE;
    localparam logic [7:0]  OFF_NOTE_OUT  = 8'hFD;
    localparam logic [7:0]  OFF_CYCLES    = 8'hFC;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RX_DATA,
        REG_RX_STATUS,
        REG_NOTE_OUT,
        REG_CYCLES
    } mmio_reg_e;

    function automatic mmio_reg_e decode_offset(input logic [7:0] off);
        case (off)
            OFF_RX_DATA:   return REG_RX_DATA;
            OFF_RX_STATUS: return REG_RX_STATUS;
            OFF_NOTE_OUT:  return REG_NOTE_OUT;
            OFF_CYCLES:    return REG_CYCLES;
            default:       return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dmem_mmio_bridge_byte_fifo.sv
// Synchronous byte FIFO for received MIDI data; simultaneous push and pop are legal,
// including a push while full when the same edge also pops.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a byte when the same edge frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Data-memory port bridge: RAM passthrough plus the MMIO window (MIDI RX FIFO, status,
// note output, cycle counter), with read data registered to match the RAM's one-cycle latency.
module dmem_mmio_bridge
    import mmio_defs::*;
#(
    parameter int DEPTH         = 16,
    parameter int RAM_ADDR_BITS = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              address_dmem,
    input  logic [31:0]              data,
    input  logic                     wren,
    input  logic                     rden,
    output logic [31:0]              q_dmem,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [31:0]              ram_data,
    output logic                     ram_wren,
    input  logic [31:0]              ram_q,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    output logic [31:0]              note_out,
    output logic                     note_strobe
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            is_mmio;
    mmio_reg_e       sel;
    logic            st_status, st_note, st_cycles;
    logic            fifo_pop, fifo_empty, fifo_full;
    logic [7:0]      fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      count8;
    logic            overflow_evt;

    logic [31:0]     rd_q, rd_d;
    logic            reg_is_mmio_q;
    logic            ovf_q, ovf_d;
    logic [31:0]     note_q, note_d;
    logic            strobe_q, strobe_d;
    logic [31:0]     cycles_q, cycles_d;

    assign is_mmio = (address_dmem[31:8] == MMIO_PREFIX);
    assign sel     = is_mmio ? decode_offset(address_dmem[7:0]) : REG_NONE;

    assign ram_addr = address_dmem[RAM_ADDR_BITS-1:0];
    assign ram_data = data;
    assign ram_wren = wren & ~is_mmio;

    assign st_status = wren & (sel == REG_RX_STATUS);
    assign st_note   = wren & (sel == REG_NOTE_OUT);
    assign st_cycles = wren & (sel == REG_CYCLES);

    // The M-stage address carries ALU results for every instruction, so only a real load pops;
    // a simultaneous store (illegal from the core) suppresses the pop.
    assign fifo_pop     = rden & ~wren & (sel == REG_RX_DATA) & ~fifo_empty;
    assign overflow_evt = rx_valid & fifo_full & ~fifo_pop;
    assign count8       = 8'(fifo_count);

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_valid),
        .pop   (fifo_pop),
        .din   (rx_byte),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        rd_d = '0;
        case (sel)
            REG_RX_DATA:   if (fifo_pop) rd_d = {23'b0, 1'b1, fifo_dout};
            REG_RX_STATUS: rd_d = {16'b0, count8, 6'b0, ovf_q, ~fifo_empty};
            REG_NOTE_OUT:  rd_d = note_q;
            REG_CYCLES:    rd_d = cycles_q;
            default:       rd_d = '0;
        endcase
    end

    always_comb begin
        ovf_d    = ovf_q;
        note_d   = note_q;
        strobe_d = 1'b0;
        cycles_d = cycles_q + 32'd1;
        if (overflow_evt)   ovf_d = 1'b1;
        else if (st_status) ovf_d = 1'b0;
        if (st_note) begin
            note_d   = data;
            strobe_d = 1'b1;
        end
        if (st_cycles) cycles_d = data;
    end

    // reg_is_mmio resets to 1 so q_dmem reads 0 out of reset regardless of what ram_q shows.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q          <= '0;
            reg_is_mmio_q <= 1'b1;
            ovf_q         <= 1'b0;
            note_q        <= '0;
            strobe_q      <= 1'b0;
            cycles_q      <= '0;
        end else begin
            rd_q          <= rd_d;
            reg_is_mmio_q <= is_mmio;
            ovf_q         <= ovf_d;
            note_q        <= note_d;
            strobe_q      <= strobe_d;
            cycles_q      <= cycles_d;
        end
    end

    assign q_dmem      = reg_is_mmio_q ? rd_q : ram_q;
    assign note_out    = note_q;
    assign note_strobe = strobe_q;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Scenario bench for dmem_mmio_bridge: expected read data is queued when a load is driven
// and popped when q_dmem is sampled one edge later.
module tb_dmem_mmio_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem, data, q_dmem, ram_data, ram_q, note_out;
    logic        wren, rden, ram_wren, rx_valid, note_strobe;
    logic [11:0] ram_addr;
    logic [7:0]  rx_byte;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ram_mem [0:4095];

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w, r, rv;
        logic [7:0]  b;
        logic        chk;
        logic [31:0] exp;
    } op_t;

    always #5 clock = ~clock;

    dmem_mmio_bridge #(.DEPTH(16), .RAM_ADDR_BITS(12)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .rden         (rden),
        .q_dmem       (q_dmem),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .note_out     (note_out),
        .note_strobe  (note_strobe)
    );

    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    function automatic op_t op(input logic [31:0] a, input logic [31:0] d, input logic w,
                               input logic r, input logic rv, input logic [7:0] b,
                               input logic chk, input logic [31:0] exp);
        op_t o;
        o.a = a; o.d = d; o.w = w; o.r = r; o.rv = rv; o.b = b; o.chk = chk; o.exp = exp;
        return o;
    endfunction

    task automatic bus(input op_t o);
        address_dmem = o.a; data = o.d; wren = o.w; rden = o.r; rx_valid = o.rv; rx_byte = o.b;
        @(posedge clock);
        #1;
        address_dmem = '0; data = '0; wren = 1'b0; rden = 1'b0; rx_valid = 1'b0; rx_byte = '0;
    endtask

    task automatic test_reset();
        op_t ops [$];
        logic [31:0] e;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (q_dmem !== 32'h0 || note_out !== 32'h0 || note_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h note=%h strobe=%b want 0/0/0", q_dmem, note_out, note_strobe);
        end
        reset = 1'b0;
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h0));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0));
        ops.push_back(op(32'hFFFFFFFC, 0, 0, 1, 0, 0, 1, 32'd2));
        ops.push_back(op(32'hFFFFFFFC, 0, 0, 1, 0, 0, 1, 32'd3));
        ops.push_back(op(32'hFFFFFFFC, 0, 0, 1, 0, 0, 1, 32'd4));
        foreach (ops[i]) begin
            if (ops[i].chk) exp_q.push_back(ops[i].exp);
            bus(ops[i]);
            if (ops[i].chk) begin
                e = exp_q.pop_front();
                checks++;
                if (q_dmem !== e) begin
                    errors++;
                    $display("FAIL reset_read[%0d]: got %h want %h", i, q_dmem, e);
                end
            end
        end
    endtask

    task automatic test_rx();
        op_t ops [$];
        logic [31:0] e;
        ops.push_back(op(0, 0, 0, 0, 1, 8'h90, 0, 0));
        ops.push_back(op(0, 0, 0, 0, 1, 8'h3C, 0, 0));
        ops.push_back(op(0, 0, 0, 0, 1, 8'h7F, 0, 0));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0301));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h190));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h13C));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h17F));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h0));
        ops.push_back(op(0, 0, 0, 0, 1, 8'h42, 0, 0));
        ops.push_back(op(32'hFFFFFFFF, 32'h1234, 1, 1, 0, 0, 0, 0));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0101));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h142));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0));
        foreach (ops[i]) begin
            if (ops[i].chk) exp_q.push_back(ops[i].exp);
            bus(ops[i]);
            if (ops[i].chk) begin
                e = exp_q.pop_front();
                checks++;
                if (q_dmem !== e) begin
                    errors++;
                    $display("FAIL rx[%0d]: got %h want %h", i, q_dmem, e);
                end
            end
        end
    endtask

    task automatic test_overflow();
        op_t ops [$];
        logic [31:0] e;
        for (int k = 0; k < 17; k++) ops.push_back(op(0, 0, 0, 0, 1, 8'(8'h10 + k), 0, 0));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h1003));
        ops.push_back(op(32'hFFFFFFFE, 0, 1, 0, 0, 0, 0, 0));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h1001));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 1, 8'hEE, 1, 32'h110));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h1001));
        ops.push_back(op(32'hFFFFFFFE, 0, 1, 0, 1, 8'h99, 0, 0));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h1003));
        for (int k = 1; k < 16; k++) ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h100 | (32'h10 + k)));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h1EE));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0002));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 1, 8'h55, 1, 32'h0));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0103));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h155));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0002));
        foreach (ops[i]) begin
            if (ops[i].chk) exp_q.push_back(ops[i].exp);
            bus(ops[i]);
            if (ops[i].chk) begin
                e = exp_q.pop_front();
                checks++;
                if (q_dmem !== e) begin
                    errors++;
                    $display("FAIL overflow[%0d]: got %h want %h", i, q_dmem, e);
                end
            end
        end
    endtask

    task automatic test_note_cycles();
        op_t ops [$];
        logic [31:0] e;
        bus(op(32'hFFFFFFFD, 32'h0000403C, 1, 0, 0, 0, 0, 0));
        checks++;
        if (note_out !== 32'h403C || note_strobe !== 1'b1) begin
            errors++;
            $display("FAIL note_store: got note=%h strobe=%b want 0000403c/1", note_out, note_strobe);
        end
        bus(op(0, 0, 0, 0, 0, 0, 0, 0));
        checks++;
        if (note_strobe !== 1'b0 || note_out !== 32'h403C) begin
            errors++;
            $display("FAIL note_strobe_end: got note=%h strobe=%b want 0000403c/0", note_out, note_strobe);
        end
        ops.push_back(op(32'hFFFFFFFD, 0, 0, 1, 0, 0, 1, 32'h403C));
        ops.push_back(op(32'hFFFFFFFC, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0));
        ops.push_back(op(32'hFFFFFFFC, 0, 0, 1, 0, 0, 1, 32'hFFFFFFFF));
        ops.push_back(op(32'hFFFFFFFC, 0, 0, 1, 0, 0, 1, 32'h0));
        ops.push_back(op(32'hFFFFFFFC, 0, 0, 1, 0, 0, 1, 32'h1));
        ops.push_back(op(32'hFFFFFF10, 32'h5, 1, 1, 0, 0, 1, 32'h0));
        foreach (ops[i]) begin
            if (ops[i].chk) exp_q.push_back(ops[i].exp);
            bus(ops[i]);
            if (ops[i].chk) begin
                e = exp_q.pop_front();
                checks++;
                if (q_dmem !== e) begin
                    errors++;
                    $display("FAIL note_cycles[%0d]: got %h want %h", i, q_dmem, e);
                end
            end
        end
    endtask

    task automatic test_ram_passthrough();
        op_t ops [$];
        logic [31:0] e;
        address_dmem = 32'd5; data = 32'hABCD; wren = 1'b1; rden = 1'b0;
        #1;
        checks++;
        if (ram_wren !== 1'b1 || ram_addr !== 12'd5 || ram_data !== 32'hABCD) begin
            errors++;
            $display("FAIL ram_store: got wren=%b addr=%h data=%h want 1/005/0000abcd", ram_wren, ram_addr, ram_data);
        end
        @(posedge clock);
        #1;
        address_dmem = 32'hFFFFFFFD; data = 32'h1; wren = 1'b1;
        #1;
        checks++;
        if (ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL mmio_no_ram_wren: got %b want 0", ram_wren);
        end
        address_dmem = '0; data = '0; wren = 1'b0;
        ops.push_back(op(32'd5, 0, 0, 1, 0, 0, 1, 32'hABCD));
        ops.push_back(op(0, 0, 0, 0, 1, 8'h77, 0, 0));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0103));
        foreach (ops[i]) begin
            if (ops[i].chk) exp_q.push_back(ops[i].exp);
            bus(ops[i]);
            if (ops[i].chk) begin
                e = exp_q.pop_front();
                checks++;
                if (q_dmem !== e) begin
                    errors++;
                    $display("FAIL ram[%0d]: got %h want %h", i, q_dmem, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        op_t ops [$];
        logic [31:0] e;
        for (int k = 1; k <= 4; k++) ops.push_back(op(0, 0, 0, 0, 1, 8'(8'hA0 + k), 0, 0));
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0503));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h177));
        foreach (ops[i]) begin
            if (ops[i].chk) exp_q.push_back(ops[i].exp);
            bus(ops[i]);
            if (ops[i].chk) begin
                e = exp_q.pop_front();
                checks++;
                if (q_dmem !== e) begin
                    errors++;
                    $display("FAIL reset_mid_pre[%0d]: got %h want %h", i, q_dmem, e);
                end
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (q_dmem !== 32'h0 || note_out !== 32'h0 || note_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got q=%h note=%h strobe=%b want 0/0/0", q_dmem, note_out, note_strobe);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        ops.delete();
        ops.push_back(op(32'hFFFFFFFE, 0, 0, 1, 0, 0, 1, 32'h0));
        ops.push_back(op(32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 32'h0));
        ops.push_back(op(32'hFFFFFFFC, 0, 0, 1, 0, 0, 1, 32'd2));
        foreach (ops[i]) begin
            if (ops[i].chk) exp_q.push_back(ops[i].exp);
            bus(ops[i]);
            if (ops[i].chk) begin
                e = exp_q.pop_front();
                checks++;
                if (q_dmem !== e) begin
                    errors++;
                    $display("FAIL reset_mid_post[%0d]: got %h want %h", i, q_dmem, e);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        address_dmem = '0; data = '0; wren = 1'b0; rden = 1'b0; rx_valid = 1'b0; rx_byte = '0;
        test_reset();
        test_rx();
        test_overflow();
        test_note_cycles();
        test_ram_passthrough();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
